bsmv_array: RTL

BSMV_ARRAY -- requirements
Module: bsmv_array

---
 rtl/bsmv_array.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/bsmv_array.sv
// bsmv_array: bit-serial matrix-vector multiplier; N_PE lanes share one single-port memory.
// Optional macro BSMV_RELU_EN clamps negative results to zero on write-back.
module bsmv_array #(
    parameter int N_PE     = 2,
    parameter int DW       = 8,
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int AW       = 7,
    parameter int MW       = 34,
    parameter int VEC_BASE = 0,
    parameter int MAT_BASE = 8,
    parameter int RES_BASE = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [MW-1:0] mem_wdata,
    input  logic [MW-1:0] mem_rdata
);
    localparam int RW = 2 * DW + $clog2(COLS);
    localparam int NG = (ROWS + N_PE - 1) / N_PE;
    localparam int LW = $clog2(N_PE + 1);
    localparam int GW = $clog2(NG + 1);
    localparam int CW = $clog2(COLS + 1);
    localparam int KW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(NG - 1);
    localparam logic [KW-1:0] BIT_LAST = KW'(DW - 1);

    typedef enum logic [2:0] {IDLE, LD_A, LD_B, WAIT, MAC, WR, FIN} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grp_q, grp_d;
    logic [CW-1:0]         col_q, col_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [KW-1:0]         bit_q, bit_d;
    logic [DW-1:0]         a_q, a_d;
    logic signed [DW-1:0]  b_q [N_PE];
    logic signed [DW-1:0]  b_d [N_PE];
    logic signed [RW-1:0]  acc_q [N_PE];
    logic signed [RW-1:0]  acc_d [N_PE];
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [MW-1:0]         wdata_q, wdata_d;

    logic [LW-1:0]         n_act;
    logic [LW-1:0]         lane_last;
    logic signed [RW-1:0]  addend;
    logic signed [RW-1:0]  wsel;

    // Operands sit in the low DW bits; the rest of the read word is don't-care.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata[MW-1:DW];

    function automatic logic [LW-1:0] lanes_in(input logic [GW-1:0] grp);
        int rem;
        rem = ROWS - int'(grp) * N_PE;
        return (rem < N_PE) ? LW'(rem) : LW'(N_PE);
    endfunction

    function automatic int row_of(input logic [GW-1:0] grp, input logic [LW-1:0] lane);
        return int'(grp) * N_PE + int'(lane);
    endfunction

    assign n_act     = lanes_in(grp_q);
    assign lane_last = n_act - LW'(1);

    always_comb begin
        // NOTE: every _d defaults to its _q value first, so no path through the case infers a latch.
        state_d = state_q;
        grp_d   = grp_q;
        col_d   = col_q;
        lane_d  = lane_q;
        bit_d   = bit_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        addend  = '0;
        wsel    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LD_A;
                    grp_d   = '0;
                    col_d   = '0;
                    acc_d   = '{default: '0};
                end
            end
            LD_A: begin
                state_d = LD_B;
                lane_d  = '0;
            end
            LD_B: begin
                // Read data lags the address by one cycle: slot 0 returns a[j], slot p returns lane p-1's b.
                if (lane_q == '0) a_d = mem_rdata[DW-1:0];
                for (int i = 0; i < N_PE; i++)
                    if (LW'(i + 1) == lane_q) b_d[i] = mem_rdata[DW-1:0];
                if (lane_q == lane_last) state_d = WAIT;
                else lane_d = lane_q + LW'(1);
            end
            WAIT: begin
                for (int i = 0; i < N_PE; i++)
                    if (LW'(i) == lane_last) b_d[i] = mem_rdata[DW-1:0];
                state_d = MAC;
                bit_d   = '0;
            end
            MAC: begin
                for (int i = 0; i < N_PE; i++) begin
                    if (LW'(i) < n_act && a_q[bit_q]) begin
                        addend   = RW'(b_q[i]) <<< bit_q;
                        acc_d[i] = (bit_q == BIT_LAST) ? acc_q[i] - addend : acc_q[i] + addend;
                    end
                end
                if (bit_q == BIT_LAST) begin
                    if (col_q == COL_LAST) begin
                        state_d = WR;
                        lane_d  = '0;
                    end else begin
                        state_d = LD_A;
                        col_d   = col_q + CW'(1);
                    end
                end else begin
                    bit_d = bit_q + KW'(1);
                end
            end
            WR: begin
                if (lane_q == lane_last) begin
                    if (grp_q == GRP_LAST) begin
                        state_d = FIN;
                    end else begin
                        state_d = LD_A;
                        grp_d   = grp_q + GW'(1);
                        col_d   = '0;
                        acc_d   = '{default: '0};
                    end
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet aligned with it.
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
        we_d    = (state_d == WR);
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            LD_A: addr_d = AW'(VEC_BASE + int'(col_d));
            LD_B: addr_d = AW'(MAT_BASE + row_of(grp_d, lane_d) * COLS + int'(col_d));
            WR: begin
                addr_d = AW'(RES_BASE + row_of(grp_d, lane_d));
                for (int i = 0; i < N_PE; i++)
                    if (LW'(i) == lane_d) wsel = acc_d[i];
`ifdef BSMV_RELU_EN
                if (wsel[RW-1]) wsel = '0;
`endif
                wdata_d = MW'(wsel);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            col_q   <= '0;
            lane_q  <= '0;
            bit_q   <= '0;
            a_q     <= '0;
            // NOTE: the small per-lane operand/accumulator arrays are flops, so they are reset like any counter.
            b_q     <= '{default: '0};
            acc_q   <= '{default: '0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            col_q   <= col_d;
            lane_q  <= lane_d;
            bit_q   <= bit_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
